fp_adder_pipe: RTL and testbench
================================

FP_ADDER_PIPE -- requirements
Module: fp_adder_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored mantissa (fraction) width; word width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand pair valid.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port InputA  input  W  operand A, IEEE-754 layout {sign, exp, frac}.
REQ-008 SHALL have port InputB  input  W  operand B, same layout.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts result.
REQ-011 SHALL have port OutputRes  output  W  sum A+B.
REQ-012 SHALL have port exception  output  1  qualified by out_valid; special input or overflow.

Function
REQ-013 SHALL be a 4-stage pipeline: S1 unpack/compare/swap so |A|>=|B|, S2 align (right-shift smaller mantissa by exponent difference, sticky discarded), S3 add/subtract mantissas, S4 normalise and pack.
REQ-014 SHALL have latency exactly 4 cycles from accepted input (in_valid && in_ready) to out_valid, absent back-pressure.
REQ-015 SHALL accept one operand pair per cycle when unstalled (throughput 1).
REQ-016 SHALL drive in_ready = !out_valid || out_ready; all stages advance together when in_ready=1 and hold all contents when 0 (global stall, no bubble collapse).
REQ-017 SHALL hold OutputRes, exception, out_valid stable while out_valid=1 and out_ready=0.
REQ-018 SHALL propagate a per-stage valid bit; bubbles (in_valid=0 on an advance cycle) travel through as invalid.
REQ-019 SHALL use hidden leading 1 for exp!=0; exp==0 inputs SHALL be flushed to signed zero (no denormal support).
REQ-020 SHALL round toward zero (truncate) shifted-out bits, in both alignment and normalisation.
REQ-021 SHALL carry a MAN_W+2-bit internal mantissa (hidden bit plus carry); carry-out SHALL shift right one and increment exponent.
REQ-022 SHALL, on subtraction, left-normalise with a leading-zero count over MAN_W+1 bits and subtract it from the exponent.
REQ-023 SHALL return +0 (all zero) on exact cancellation; result sign otherwise = sign of larger-magnitude operand.
REQ-024 SHALL flush to signed zero, exception=0, when normalised exponent <= 0.
REQ-025 SHALL, when normalised exponent >= 2^EXP_W-1, output {sign, all-ones exp, zero frac} with exception=1.
REQ-026 SHALL, when either input exp is all ones (Inf or NaN), set exception=1 and output {0, all-ones exp, 1 then zeros} (quiet NaN); this overrides REQ-025.
REQ-027 SHALL give identical results for A+B and B+A.

Reset
REQ-028 SHALL, on rst=1, immediately clear all stage valid bits, out_valid=0, OutputRes=0, exception=0, irrespective of clk.
REQ-029 SHALL drive in_ready=1 throughout and after reset.
REQ-030 SHALL discard in-flight operations on reset mid-operation; no stale result appears after release.

Verification
REQ-031 Single op: A=0x4799FF04, B=0x47838F88 -> after 4 cycles out_valid=1, OutputRes=0x480EC746, exception=0.
REQ-032 Mixed sign: A=0x4799FF04, B=0xC75DD502 -> OutputRes=0x46AC520C, exception=0; swapped operands give the same result.
REQ-033 Specials: A=0x7F800000, B=0x41480000 -> exception=1, OutputRes=0x7FC00000; A=0xFF853000, B=0xC1480000 -> exception=1.
REQ-034 Back-pressure: 6 back-to-back inputs, out_ready=0 for cycles 5-8 -> in_ready=0 while stalled, results held, all 6 delivered in order, none lost or duplicated.
REQ-035 Edge cases: A=0x3F800000, B=0xBF800000 -> 0x00000000; A=B=0x7F7FFFFF -> 0x7F800000, exception=1.
REQ-036 Reset mid-flight: assert rst with 3 ops in flight -> out_valid=0 at once; no output for 4 cycles after release without new input.

Source files
------------

// File: rtl/fp_adder_pipe.sv
// Four-stage pipelined floating-point adder (truncating, no denormals) with a
// valid/ready handshake and a global stall driven by the output register.
module fp_adder_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [EXP_W+MAN_W:0]       InputA,
   input  logic [EXP_W+MAN_W:0]       InputB,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [EXP_W+MAN_W:0]       OutputRes,
   output logic                       exception
);

   localparam int W   = 1 + EXP_W + MAN_W;
   localparam int M   = MAN_W + 2;
   localparam int LZW = $clog2(MAN_W + 2);
   localparam int EW  = EXP_W + 2;

   // Index of the highest set bit, expressed as a distance from bit MAN_W.
   function automatic logic [LZW-1:0] count_lz(input logic [MAN_W:0] v);
      count_lz = LZW'(MAN_W + 1);
      for (int i = 0; i <= MAN_W; i++) begin
         if (v[i]) count_lz = LZW'(MAN_W - i);
      end
   endfunction

   logic advance;
   assign in_ready = !out_valid || out_ready;
   assign advance  = in_ready;

   // Stage 1: unpack, flush exp==0 operands to zero, order by magnitude
   logic [EXP_W-1:0] exp_a, exp_b;
   logic             zero_a, zero_b, a_is_big, special_in;
   logic [W-2:0]     mag_a, mag_b;
   logic [MAN_W:0]   man_a, man_b;

   always_comb begin
      exp_a      = InputA[MAN_W +: EXP_W];
      exp_b      = InputB[MAN_W +: EXP_W];
      zero_a     = (exp_a == '0);
      zero_b     = (exp_b == '0);
      mag_a      = zero_a ? '0 : InputA[W-2:0];
      mag_b      = zero_b ? '0 : InputB[W-2:0];
      man_a      = zero_a ? '0 : {1'b1, InputA[MAN_W-1:0]};
      man_b      = zero_b ? '0 : {1'b1, InputB[MAN_W-1:0]};
      a_is_big   = (mag_a >= mag_b);
      special_in = (&exp_a) || (&exp_b);
   end

   logic             s1_valid, s1_special, s1_sign_big, s1_sign_small;
   logic [EXP_W-1:0] s1_exp_big, s1_exp_small;
   logic [MAN_W:0]   s1_man_big, s1_man_small;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid      <= 1'b0;
         s1_special    <= 1'b0;
         s1_sign_big   <= 1'b0;
         s1_sign_small <= 1'b0;
         s1_exp_big    <= '0;
         s1_exp_small  <= '0;
         s1_man_big    <= '0;
         s1_man_small  <= '0;
      end else if (advance) begin
         s1_valid      <= in_valid;
         s1_special    <= special_in;
         s1_sign_big   <= a_is_big ? InputA[W-1] : InputB[W-1];
         s1_sign_small <= a_is_big ? InputB[W-1] : InputA[W-1];
         s1_exp_big    <= a_is_big ? exp_a : exp_b;
         s1_exp_small  <= a_is_big ? exp_b : exp_a;
         s1_man_big    <= a_is_big ? man_a : man_b;
         s1_man_small  <= a_is_big ? man_b : man_a;
      end
   end

   // Stage 2: align the smaller mantissa; shifted-out bits are simply dropped
   logic [31:0]    shift_amt;
   logic [MAN_W:0] man_aligned;

   always_comb begin
      shift_amt = 32'(s1_exp_big - s1_exp_small);
      if (shift_amt >= 32'(MAN_W + 1)) man_aligned = '0;
      else                             man_aligned = s1_man_small >> shift_amt;
   end

   logic             s2_valid, s2_special, s2_sign, s2_sub;
   logic [EXP_W-1:0] s2_exp;
   logic [MAN_W:0]   s2_man_big, s2_man_small;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid     <= 1'b0;
         s2_special   <= 1'b0;
         s2_sign      <= 1'b0;
         s2_sub       <= 1'b0;
         s2_exp       <= '0;
         s2_man_big   <= '0;
         s2_man_small <= '0;
      end else if (advance) begin
         s2_valid     <= s1_valid;
         s2_special   <= s1_special;
         s2_sign      <= s1_sign_big;
         s2_sub       <= s1_sign_big ^ s1_sign_small;
         s2_exp       <= s1_exp_big;
         s2_man_big   <= s1_man_big;
         s2_man_small <= man_aligned;
      end
   end

   // Stage 3: magnitude add or subtract (big >= small, so never negative)
   logic [M-1:0] sum;

   always_comb begin
      if (s2_sub) sum = {1'b0, s2_man_big} - {1'b0, s2_man_small};
      else        sum = {1'b0, s2_man_big} + {1'b0, s2_man_small};
   end

   logic             s3_valid, s3_special, s3_sign;
   logic [EXP_W-1:0] s3_exp;
   logic [M-1:0]     s3_sum;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s3_valid   <= 1'b0;
         s3_special <= 1'b0;
         s3_sign    <= 1'b0;
         s3_exp     <= '0;
         s3_sum     <= '0;
      end else if (advance) begin
         s3_valid   <= s2_valid;
         s3_special <= s2_special;
         s3_sign    <= s2_sign;
         s3_exp     <= s2_exp;
         s3_sum     <= sum;
      end
   end

   // Stage 4: normalise, then resolve specials, underflow and overflow
   logic [LZW-1:0]      lz;
   logic signed [EW-1:0] exp_n;
   logic [MAN_W-1:0]    frac_n;
   logic [W-1:0]        res;
   logic                res_exc;

   always_comb begin
      lz      = count_lz(s3_sum[MAN_W:0]);
      exp_n   = '0;
      frac_n  = '0;
      res     = '0;
      res_exc = 1'b0;
      if (s3_sum[M-1]) begin
         exp_n  = signed'(EW'(s3_exp)) + signed'(EW'(1));
         frac_n = s3_sum[MAN_W:1];
      end else begin
         exp_n  = signed'(EW'(s3_exp)) - signed'(EW'(lz));
         frac_n = s3_sum[MAN_W-1:0] << lz;
      end
      if (s3_special) begin
         res     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
         res_exc = 1'b1;
      end else if (s3_sum == '0) begin
         res = '0;
      end else if (exp_n <= signed'(EW'(0))) begin
         res = {s3_sign, {(W-1){1'b0}}};
      end else if (exp_n >= signed'(EW'({EXP_W{1'b1}}))) begin
         res     = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         res_exc = 1'b1;
      end else begin
         res = {s3_sign, exp_n[EXP_W-1:0], frac_n};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         OutputRes <= '0;
         exception <= 1'b0;
      end else if (advance) begin
         out_valid <= s3_valid;
         OutputRes <= res;
         exception <= res_exc;
      end
   end

endmodule

// File: tb/tb_fp_adder_pipe.sv
// Directed-vector bench for fp_adder_pipe: latency, arithmetic, specials,
// back-pressure ordering and mid-flight reset.
module tb_fp_adder_pipe;

   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam int W     = 1 + EXP_W + MAN_W;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready, out_valid, out_ready, exception;
   logic [W-1:0] InputA, InputB, OutputRes;

   int checks = 0;
   int errors = 0;

   logic [31:0] bp_a [6];
   logic [31:0] bp_b [6];
   logic [31:0] bp_r [6];
   logic        bp_e [6];

   fp_adder_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .InputA   (InputA),
      .InputB   (InputB),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .OutputRes(OutputRes),
      .exception(exception)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Sends one operand pair, measures latency to out_valid, checks the result.
   task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] res, input logic exc);
      int lat;
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      InputA    = a;
      InputB    = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat      = 1;
      while (!out_valid && lat < 12) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checkOutput({tag, "_lat"}, 32'(lat), 32'd4);
      checkOutput({tag, "_res"}, OutputRes, res);
      checkOutput({tag, "_exc"}, {31'd0, exception}, {31'd0, exc});
      @(posedge clk);
      #1;
   endtask

   initial begin
      int   sent, nout, cyc, stalls, seen;
      logic acc;

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      InputA    = '0;
      InputB    = '0;
      #12;
      checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_result", OutputRes, 32'd0);
      checkOutput("rst_exception", {31'd0, exception}, 32'd0);
      checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;

      applyStimulus("single",        32'h4799FF04, 32'h47838F88, 32'h480EC746, 1'b0);
      applyStimulus("mixed",         32'h4799FF04, 32'hC75DD502, 32'h46AC520C, 1'b0);
      applyStimulus("mixed_swap",    32'hC75DD502, 32'h4799FF04, 32'h46AC520C, 1'b0);
      applyStimulus("inf",           32'h7F800000, 32'h41480000, 32'h7FC00000, 1'b1);
      applyStimulus("nan_neg",       32'hFF853000, 32'hC1480000, 32'h7FC00000, 1'b1);
      applyStimulus("cancel",        32'h3F800000, 32'hBF800000, 32'h00000000, 1'b0);
      applyStimulus("overflow",      32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1);
      applyStimulus("one_plus_two",  32'h3F800000, 32'h40000000, 32'h40400000, 1'b0);
      applyStimulus("two_plus_one",  32'h40000000, 32'h3F800000, 32'h40400000, 1'b0);
      applyStimulus("zero_in",       32'h00000000, 32'h40400000, 32'h40400000, 1'b0);
      applyStimulus("denorm_flush",  32'h00000001, 32'h3F800000, 32'h3F800000, 1'b0);
      applyStimulus("trunc_full",    32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0);
      applyStimulus("trunc_partial", 32'h3F800000, 32'h34400000, 32'h3F800001, 1'b0);
      applyStimulus("trunc_norm",    32'h3F800003, 32'h3F800000, 32'h40000001, 1'b0);
      applyStimulus("underflow",     32'h80800001, 32'h00800000, 32'h80000000, 1'b0);

      // Six back-to-back operations with the consumer stalled in cycles 5-8
      bp_a[0] = 32'h4799FF04; bp_b[0] = 32'h47838F88; bp_r[0] = 32'h480EC746; bp_e[0] = 1'b0;
      bp_a[1] = 32'h4799FF04; bp_b[1] = 32'hC75DD502; bp_r[1] = 32'h46AC520C; bp_e[1] = 1'b0;
      bp_a[2] = 32'h3F800000; bp_b[2] = 32'h40000000; bp_r[2] = 32'h40400000; bp_e[2] = 1'b0;
      bp_a[3] = 32'h3F800000; bp_b[3] = 32'hBF800000; bp_r[3] = 32'h00000000; bp_e[3] = 1'b0;
      bp_a[4] = 32'h3F800000; bp_b[4] = 32'h3F800000; bp_r[4] = 32'h40000000; bp_e[4] = 1'b0;
      bp_a[5] = 32'h7F7FFFFF; bp_b[5] = 32'h7F7FFFFF; bp_r[5] = 32'h7F800000; bp_e[5] = 1'b1;
      sent   = 0;
      nout   = 0;
      cyc    = 0;
      stalls = 0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      InputA    = bp_a[0];
      InputB    = bp_b[0];
      while (nout < 6 && cyc < 40) begin
         @(negedge clk);
         if (out_valid) begin
            if (nout < 6) begin
               checkOutput($sformatf("bp%0d_res", nout), OutputRes, bp_r[nout]);
               checkOutput($sformatf("bp%0d_exc", nout), {31'd0, exception}, {31'd0, bp_e[nout]});
            end
            if (!out_ready) begin
               stalls++;
               checkOutput("bp_in_ready_stalled", {31'd0, in_ready}, 32'd0);
            end else begin
               nout++;
            end
         end
         acc = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            sent++;
            if (sent < 6) begin
               InputA = bp_a[sent];
               InputB = bp_b[sent];
            end else begin
               in_valid = 1'b0;
            end
         end
         cyc++;
         out_ready = !(cyc >= 5 && cyc <= 8);
      end
      checkOutput("bp_delivered", 32'(nout), 32'd6);
      checkOutput("bp_sent", 32'(sent), 32'd6);
      checkOutput("bp_stall_cycles", 32'(stalls), 32'd4);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      seen      = 0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      checkOutput("bp_no_duplicate", 32'(seen), 32'd0);

      // Reset with one result at the output and three operations in flight
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      InputA   = 32'h4799FF04;
      InputB   = 32'h47838F88;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      in_valid = 1'b0;
      rst      = 1'b1;
      #1;
      checkOutput("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("mid_rst_result", OutputRes, 32'd0);
      checkOutput("mid_rst_exception", {31'd0, exception}, 32'd0);
      checkOutput("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      checkOutput("post_rst_no_stale", 32'(seen), 32'd0);
      checkOutput("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
